// File: rtl/imem_loader.sv
// Streams bytes into 32-bit big-endian words and writes them to instruction memory,
// holding the CPU in reset for the duration of a load session.
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] word_count,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_t;

    state_t          state, state_nx;
    logic [1:0]      byte_idx;
    logic [ADDR_W:0] target;
    logic            last_word;

    assign last_word = (words_loaded + 1'b1) == target;
    assign cpu_hold  = busy;

    always_comb begin
        state_nx   = state;
        byte_ready = 1'b0;
        wr_en      = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start && !abort) state_nx = COLLECT;
            end
            COLLECT: begin
                byte_ready = 1'b1;
                if (abort)                            state_nx = IDLE;
                else if (byte_valid && byte_idx == 2'd3) state_nx = WRITE;
            end
            WRITE: begin
                // An abort landing on the write cycle cancels that word entirely.
                if (abort) state_nx = IDLE;
                else begin
                    wr_en    = 1'b1;
                    state_nx = last_word ? FINISH : COLLECT;
                end
            end
            FINISH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state        <= IDLE;
            wr_addr      <= '0;
            wr_data      <= '0;
            done         <= 1'b0;
            words_loaded <= '0;
            byte_idx     <= '0;
            target       <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        wr_addr      <= '0;
                        byte_idx     <= '0;
                        words_loaded <= '0;
                        done         <= 1'b0;
                        // A zero count means a full-memory load.
                        target <= (word_count == '0) ? (ADDR_W+1)'(DEPTH)
                                                     : {1'b0, word_count};
                    end
                end
                COLLECT: begin
                    if (byte_valid && !abort) begin
                        wr_data  <= {wr_data[23:0], byte_data};
                        byte_idx <= byte_idx + 1'b1;
                    end
                end
                WRITE: begin
                    if (wr_en) begin
                        wr_addr      <= (wr_addr == ADDR_W'(DEPTH-1)) ? '0 : wr_addr + 1'b1;
                        words_loaded <= words_loaded + 1'b1;
                    end
                end
                FINISH: done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven sessions, hand-written corner
// sequences and randomized sessions scored against a byte-stream reference model.
module tb_imem_loader;

    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic          CLOCK_50 = 1'b0;
    logic          reset, start, abort;
    logic [AW-1:0] word_count;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          byte_ready, wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          cpu_hold, busy, done;
    logic [AW:0]   words_loaded;

    imem_loader #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .abort(abort),
        .word_count(word_count), .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .words_loaded(words_loaded)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int wc;    // word_count applied
        int mode;  // 0 continuous valid, 1 toggled valid, 2 random valid
        int ab;    // abort after this many accepted bytes, -1 none
        int wl;    // expected words_loaded
        int dn;    // expected done
    } vec_t;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            dbl     = 0;
    logic          prev_wr = 1'b0;
    logic [AW+31:0] cap[$];

    // Memory-side monitor: record every write and flag multi-cycle strobes.
    always @(negedge CLOCK_50) begin
        if (wr_en) begin
            cap.push_back({wr_addr, wr_data});
            if (prev_wr) dbl++;
        end
        prev_wr <= wr_en;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic feed(input bq_t bytes, input int mode, input int abort_at, input int budget,
                        output int accepted, output int done_at);
        int t;
        bit took, fin;
        t = 0; fin = 1'b0; accepted = 0; done_at = -1;
        while (!fin) begin
            if (abort_at >= 0 && accepted == abort_at) begin
                abort = 1'b1; byte_valid = 1'b0;
                step(); t++;
                abort = 1'b0; fin = 1'b1;
            end else begin
                case (mode)
                    0:       byte_valid = 1'b1;
                    1:       byte_valid = (t % 2 == 0);
                    default: byte_valid = 1'($urandom_range(0, 1));
                endcase
                if (accepted < bytes.size()) byte_data = bytes[accepted];
                else                         byte_valid = 1'b0;
                took = byte_valid && byte_ready;
                step(); t++;
                if (took) accepted++;
                if (done && done_at < 0) done_at = t;
                if (!busy) fin = 1'b1;
                else if (t >= budget) begin
                    check("session_timeout", 64'(1), 64'(0));
                    abort = 1'b1; step(); abort = 1'b0;
                    fin = 1'b1;
                end
            end
        end
        byte_valid = 1'b0;
    endtask

    // pat: 0 random bytes, 1 incrementing bytes, 2 fixed two-word program
    task automatic run_session(input int wc, input int mode, input int abort_at, input int pat,
                               input int exp_wl, input int exp_dn, output int done_at);
        bq_t        b;
        logic [7:0] fx[8];
        logic [31:0] w;
        int nw, acc, written, bad;
        fx = '{8'h00, 8'h22, 8'h40, 8'h20, 8'h8C, 8'h01, 8'h00, 8'h04};
        nw = (wc == 0) ? DEPTH : wc;
        for (int i = 0; i < nw * 4; i++) begin
            case (pat)
                0:       b.push_back(8'($urandom));
                1:       b.push_back(8'(i));
                default: b.push_back(fx[i % 8]);
            endcase
        end
        cap.delete();
        word_count = AW'(wc); start = 1'b1;
        step();
        start = 1'b0;
        feed(b, mode, abort_at, nw * 4 * 6 + 50, acc, done_at);
        // Only fully written words count; an abort on a write cycle loses that word.
        if (abort_at < 0)       written = nw;
        else if (abort_at == 0) written = 0;
        else                    written = (abort_at - 1) / 4;
        check("words_loaded", 64'(words_loaded), 64'(written));
        check("done", 64'(done), 64'(abort_at < 0));
        check("wr_addr_end", 64'(wr_addr), 64'(written % DEPTH));
        check("cpu_hold_end", 64'({cpu_hold, busy}), 64'(0));
        check("write_count", 64'(cap.size()), 64'(written));
        bad = 0;
        for (int i = 0; i < written && i < cap.size(); i++) begin
            w = {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
            if (cap[i] !== {AW'(i % DEPTH), w}) bad++;
        end
        check("write_contents", 64'(bad), 64'(0));
        if (abort_at < 0) check("bytes_accepted", 64'(acc), 64'(nw * 4));
        if (exp_wl >= 0) begin
            check("vec_words_loaded", 64'(words_loaded), 64'(exp_wl));
            check("vec_done", 64'(done), 64'(exp_dn));
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[7];
        bq_t  b;
        int   da, t, acc, wc, mode, ab;

        tbl[0] = '{2, 0, -1, 2, 1};
        tbl[1] = '{1, 1, -1, 1, 1};
        tbl[2] = '{5, 0, 10, 2, 0};
        tbl[3] = '{3, 2, -1, 3, 1};
        tbl[4] = '{4, 0,  8, 1, 0};
        tbl[5] = '{3, 1,  0, 0, 0};
        tbl[6] = '{5, 1,  6, 1, 0};

        reset = 1'b1; start = 1'b0; abort = 1'b0; word_count = '0;
        byte_data = '0; byte_valid = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst_outputs", 64'({byte_ready, wr_en, cpu_hold, busy, done}), 64'(0));
        check("rst_wr_addr", 64'(wr_addr), 64'(0));
        check("rst_wr_data", 64'(wr_data), 64'(0));
        check("rst_words_loaded", 64'(words_loaded), 64'(0));

        // start and abort together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1; word_count = AW'(5);
        step();
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 64'({busy, byte_ready, cpu_hold}), 64'(0));
        step();
        check("start_abort_stay", 64'(busy), 64'(0));

        run_session(2, 0, -1, 2, 2, 1, da);
        check("two_word_done_cycle", 64'(da), 64'(11));

        for (int i = 0; i < 7; i++)
            run_session(tbl[i].wc, tbl[i].mode, tbl[i].ab, 0, tbl[i].wl, tbl[i].dn, da);

        run_session(0, 0, -1, 1, DEPTH, 1, da);
        check("full_load_done_cycle", 64'(da), 64'(DEPTH * 5 + 1));

        // Reset landing on a write cycle.
        cap.delete();
        word_count = AW'(3); start = 1'b1;
        step();
        start = 1'b0; byte_valid = 1'b1; t = 0;
        while (!wr_en && t < 20) begin
            byte_data = 8'($urandom);
            step(); t++;
        end
        check("reach_write", 64'(wr_en), 64'(1));
        byte_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_outputs", 64'({byte_ready, wr_en, cpu_hold, busy, done}), 64'(0));
        check("rst_mid_addr_data", 64'({wr_addr, wr_data}), 64'(0));
        check("rst_mid_words", 64'(words_loaded), 64'(0));

        // A second start while busy must not relatch the count.
        cap.delete();
        for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
        word_count = AW'(2); start = 1'b1;
        step();
        word_count = AW'(7);
        step();
        start = 1'b0;
        feed(b, 0, -1, 100, acc, da);
        check("restart_ignored_wl", 64'(words_loaded), 64'(2));
        check("restart_ignored_done", 64'(done), 64'(1));
        check("restart_ignored_writes", 64'(cap.size()), 64'(2));

        for (int r = 0; r < 12; r++) begin
            wc   = int'($urandom_range(1, 12));
            mode = int'($urandom_range(0, 2));
            ab   = -1;
            if ($urandom_range(0, 2) == 0) ab = int'($urandom_range(0, wc * 4 - 1));
            run_session(wc, mode, ab, 0, -1, 0, da);
        end

        step();
        check("single_cycle_wr_en", 64'(dbl), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 10, instruction-memory word-address width (matches the 10-bit PC).
REQ-002 Parameter DEPTH, default 1024, instruction-memory depth in words (2**ADDR_W).
REQ-003 CLOCK_50  in  1  sole clock, all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse: begin a load session.
REQ-006 abort  in  1  terminate the current session, discarding any partial word.
REQ-007 word_count  in  ADDR_W  number of words to load, sampled on start; 0 means DEPTH.
REQ-008 byte_data  in  8  incoming program byte.
REQ-009 byte_valid  in  1  byte_data is valid.
REQ-010 byte_ready  out  1  loader accepts a byte this cycle.
REQ-011 wr_en  out  1  instruction-memory write strobe.
REQ-012 wr_addr  out  ADDR_W  instruction-memory write address.
REQ-013 wr_data  out  32  instruction word to write.
REQ-014 cpu_hold  out  1  holds the processor FSM in reset while loading.
REQ-015 busy  out  1  session in progress.
REQ-016 done  out  1  sticky: last session completed all words.
REQ-017 words_loaded  out  ADDR_W+1  words written in the current or last session.

Function
REQ-018 The FSM SHALL have the states IDLE, COLLECT, WRITE and FINISH.
REQ-019 IDLE: byte_ready=0, busy=0; on start, SHALL go to COLLECT, clear wr_addr, byte index, words_loaded and done, and latch word_count.
REQ-020 COLLECT: byte_ready=1; a byte SHALL transfer only when byte_valid and byte_ready are both 1 in the same cycle.
REQ-021 Bytes SHALL be assembled big-endian: the first byte goes to [31:24] and the fourth to [7:0].
REQ-022 On the fourth accepted byte, the FSM SHALL enter WRITE on the next cycle with the full word in wr_data.
REQ-023 WRITE: wr_en=1 for exactly one cycle, byte_ready=0; wr_addr and wr_data SHALL be stable during that cycle.
REQ-024 After WRITE, wr_addr SHALL increment modulo DEPTH and words_loaded SHALL increment.
REQ-025 After WRITE, the FSM SHALL go to FINISH if words_loaded equals the latched count (0 treated as DEPTH); otherwise it SHALL return to COLLECT.
REQ-026 FINISH SHALL last one cycle: set done=1, then go to IDLE.
REQ-027 Minimum cost per word is 5 cycles (4 byte cycles plus 1 write cycle); a session SHALL accept no byte in the WRITE cycle.
REQ-028 cpu_hold and busy SHALL be 1 in COLLECT, WRITE and FINISH; cpu_hold SHALL fall in the cycle the FSM enters IDLE.
REQ-029 start SHALL be ignored while busy.
REQ-030 abort in COLLECT or WRITE SHALL force IDLE next cycle with done=0 and wr_en suppressed in that cycle; words already written remain written; words_loaded holds.
REQ-031 abort and start asserted together in IDLE: abort wins, and the FSM SHALL stay in IDLE.
REQ-032 If byte_valid arrives while byte_ready=0, the byte SHALL NOT be consumed; the source must hold it.
REQ-033 wr_addr SHALL never exceed DEPTH-1; a DEPTH-word load ends with wr_addr wrapped to 0.
REQ-034 done SHALL remain set until the next accepted start or reset.

Reset
REQ-035 On reset: state=IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, busy=0, done=0, words_loaded=0, byte index=0.
REQ-036 Reset SHALL override start and abort; a reset mid-session SHALL discard the partial word with no write issued.

Verification
REQ-037 start with word_count=2, bytes 00 22 40 20 8C 01 00 04 streamed with continuous valid -> writes 0x00224020@0 and 0x8C010004@1, done=1 after 11 cycles, words_loaded=2.
REQ-038 Valid toggled 1-0-1-0 across a word -> byte_ready honoured, each byte accepted exactly once, wr_data correct, wr_en a single pulse.
REQ-039 abort after 2 bytes of word 3 with word_count=5 -> no 3rd write, done=0, words_loaded=2, cpu_hold low the next cycle.
REQ-040 word_count=0, 4096 incrementing bytes -> 1024 writes covering addresses 0..1023, wr_addr ends at 0, words_loaded=1024, done=1.
REQ-041 reset asserted during WRITE -> wr_en low the next cycle, all outputs at reset values, and a second start is ignored while busy.
REQ-042 start and abort asserted together in IDLE -> busy stays 0, no byte_ready.
